jpeg_lift53: RTL and testbench
==============================

// Module: jpeg_lift53
// PURPOSE
//   One LeGall 5/3 integer lifting step for the JPEG-2000 style wavelet datapath.
//   Combines a centre sample s_s with its left and right neighbours (l_s, r_s).
//   Performs either a predict step (high-pass) or an update step (low-pass).
//   Runs in forward or inverse direction; the result is registered.
//   Sits beside the SDRAM controller in top; the sample sequencer presents one triple per enabled cycle.
// PARAMETERS
//   WIDTH     16  sample width, two's-complement signed
//   SATURATE  0   0: result wraps modulo 2^WIDTH; 1: result clamps to the signed WIDTH range
// PORTS
//   clk        in   1      rising-edge clock; the only clock
//   reset_l    in   1      asynchronous, active-low reset
//   l_s        in   WIDTH  left neighbour sample, signed
//   r_s        in   WIDTH  right neighbour sample, signed
//   s_s        in   WIDTH  centre sample being lifted, signed
//   lohipass   in   1      1 = low-pass update step; 0 = high-pass predict step
//   fwd_inv    in   1      1 = forward transform; 0 = inverse transform
//   ex         in   1      execute strobe; a triple is sampled on each clk edge where ex=1
//   res_s      out  WIDTH  lifted result, signed, registered
//   res_vld    out  1      1 for the cycle after an ex=1 edge
// BEHAVIOUR
//   - Reset (reset_l=0) is asynchronous: res_s=0 and res_vld=0 immediately, and they stay 0 while reset is held.
//   - After reset_l releases, the first edge with ex=1 is processed normally; there is no warm-up cycle.
//   - sum = l_s + r_s, computed sign-extended to WIDTH+2 bits, so it never overflows.
//   - Predict term: p = sum >>> 1 (arithmetic shift, i.e. floor).
//   - Update term:  u = (sum + 2) >>> 2 (floor, with rounding offset 2).
//   - The raw result y is computed at WIDTH+2 bits:
//       fwd_inv=1, lohipass=0 : y = s_s - p
//       fwd_inv=1, lohipass=1 : y = s_s + u
//       fwd_inv=0, lohipass=0 : y = s_s + p
//       fwd_inv=0, lohipass=1 : y = s_s - u
//   - SATURATE=0: res_s takes y[WIDTH-1:0], so results wrap.
//   - SATURATE=1: y is clamped to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
//   - Latency is 1 cycle. On an edge with ex=1, res_s <= f(inputs) and res_vld <= 1.
//   - On an edge with ex=0, res_s holds its previous value and res_vld <= 0.
//   - Back-to-back ex=1 gives one result per cycle, with no stall or handshake.
//   - lohipass and fwd_inv are sampled together with the data; changing them between cycles is legal.
//   - Inverse undoes forward exactly: inverse(forward(s)) == s for the same l_s, r_s and mode, when no wrap or clamp occurs.
//   - Reset asserted mid-stream discards the pending result; after reset_l releases, the next edge with ex=1 is processed normally.
//   - No combinational path from any input to any output.
// TESTING
//   1. Hold reset_l=0 with ex=1 and arbitrary data -> res_s=0 and res_vld=0. Assert reset_l mid-stream -> outputs clear at once, without waiting for a clock edge.
//   2. Forward high-pass, l=10, r=20, s=100, ex=1 -> next cycle res_s=85, res_vld=1.
//      Then inverse high-pass with the same l and r and s=85 -> res_s=100.
//   3. Forward low-pass, l=4, r=6, s=50 -> 53.
//      Inverse low-pass, s=53 -> 50.
//      Negative case: l=-3, r=0, s=0, forward high-pass -> res_s=2 (p=-2).
//   4. Overflow: s=0x7FFF, l=r=0xFFFE, forward high-pass.
//      SATURATE=0 -> res_s=0x8001. SATURATE=1 -> res_s=0x7FFF.
//   5. Present the case-2 triple with ex=1 for one cycle, then ex=0 for 3 cycles with changing inputs.
//      -> res_s stays 85 for all 3 cycles; res_vld is high for 1 cycle only.
//   6. Random streaming, 10k triples, ex toggling randomly and all four modes.
//      -> res_s matches the reference model each cycle after an ex=1 edge.
//      -> inverse(forward(s)) returns s for non-overflowing data.

Source files
------------

// File: rtl/jpeg_lift53.sv
// LeGall 5/3 integer lifting step (predict/update, forward/inverse) with a
// registered result, optional saturation to the signed WIDTH range.
module jpeg_lift53 #(
  parameter int unsigned WIDTH    = 16,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset_l,
  input  logic [WIDTH-1:0] l_s,
  input  logic [WIDTH-1:0] r_s,
  input  logic [WIDTH-1:0] s_s,
  input  logic             lohipass,
  input  logic             fwd_inv,
  input  logic             ex,
  output logic [WIDTH-1:0] res_s,
  output logic             res_vld
);

  localparam int unsigned EW = WIDTH + 2;

  logic signed [EW-1:0] l_ext, r_ext, s_ext;
  logic signed [EW-1:0] sum, p_term, u_term, y;
  logic                 ovf;
  logic [WIDTH-1:0]     res_d, res_q;
  logic                 vld_d, vld_q;

  always_comb begin
    l_ext  = {{2{l_s[WIDTH-1]}}, l_s};
    r_ext  = {{2{r_s[WIDTH-1]}}, r_s};
    s_ext  = {{2{s_s[WIDTH-1]}}, s_s};
    sum    = l_ext + r_ext;
    p_term = sum >>> 1;
    u_term = (sum + EW'(2)) >>> 2;
    unique case ({fwd_inv, lohipass})
      2'b10:   y = s_ext - p_term;
      2'b11:   y = s_ext + u_term;
      2'b00:   y = s_ext + p_term;
      default: y = s_ext - u_term;
    endcase
    // y fits in WIDTH bits only when its top three bits agree.
    ovf = (y[EW-1:WIDTH-1] != '0) && (y[EW-1:WIDTH-1] != '1);
  end

  always_comb begin
    res_d = res_q;
    vld_d = 1'b0;
    if (ex) begin
      vld_d = 1'b1;
      if (SATURATE && ovf)
        res_d = y[EW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      else
        res_d = y[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      res_q <= '0;
      vld_q <= 1'b0;
    end else begin
      res_q <= res_d;
      vld_q <= vld_d;
    end
  end

  assign res_s   = res_q;
  assign res_vld = vld_q;

endmodule

// File: tb/tb_jpeg_lift53.sv
// Directed and randomised checks of jpeg_lift53 in wrapping and saturating builds.
module tb_jpeg_lift53;

  logic               clk = 1'b0;
  logic               reset_l;
  logic signed [15:0] l_s, r_s, s_s;
  logic               lohipass, fwd_inv, ex;
  logic [15:0]        res0, res1;
  logic               vld0, vld1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  jpeg_lift53 #(.WIDTH(16), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .reset_l(reset_l), .l_s(l_s), .r_s(r_s), .s_s(s_s),
    .lohipass(lohipass), .fwd_inv(fwd_inv), .ex(ex),
    .res_s(res0), .res_vld(vld0)
  );

  jpeg_lift53 #(.WIDTH(16), .SATURATE(1'b1)) u_sat (
    .clk(clk), .reset_l(reset_l), .l_s(l_s), .r_s(r_s), .s_s(s_s),
    .lohipass(lohipass), .fwd_inv(fwd_inv), .ex(ex),
    .res_s(res1), .res_vld(vld1)
  );

  // Floor division written independently of shifting.
  function automatic int fdiv(input int a, input int d);
    int q;
    q = a / d;
    if ((a % d) != 0 && a < 0) q = q - 1;
    return q;
  endfunction

  function automatic int ref_y(input int l, input int r, input int s,
                               input bit lp, input bit fi);
    int sum, p, u;
    sum = l + r;
    p   = fdiv(sum, 2);
    u   = fdiv(sum + 2, 4);
    if (fi && !lp)      return s - p;
    else if (fi && lp)  return s + u;
    else if (!fi && !lp) return s + p;
    else                return s - u;
  endfunction

  function automatic logic [15:0] wrap16(input int y);
    logic [31:0] t;
    t = y;
    return t[15:0];
  endfunction

  function automatic logic [15:0] sat16(input int y);
    int c;
    c = y;
    if (c > 32767) c = 32767;
    if (c < -32768) c = -32768;
    return wrap16(c);
  endfunction

  // Present one triple for one rising edge and land #1 after it.
  task automatic drive(input int l, input int r, input int s,
                       input bit lp, input bit fi, input bit e);
    l_s = 16'(l); r_s = 16'(r); s_s = 16'(s);
    lohipass = lp; fwd_inv = fi; ex = e;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset_l = 1'b0;
    drive(10, 20, 100, 1'b0, 1'b1, 1'b1);
    drive(1, 2, 3, 1'b1, 1'b1, 1'b1);
    n_tests++;
    if (res0 !== 16'd0 || vld0 !== 1'b0) begin
      n_fail++; $display("FAIL reset_hold: res=%0h vld=%b, expected 0/0", res0, vld0);
    end
    reset_l = 1'b1;
    drive(10, 20, 100, 1'b0, 1'b1, 1'b1);
    n_tests++;
    if (res0 !== 16'd85 || vld0 !== 1'b1) begin
      n_fail++; $display("FAIL reset_first_ex: res=%0d vld=%b, expected 85/1", res0, vld0);
    end
    #2 reset_l = 1'b0;
    #1;
    n_tests++;
    if (res0 !== 16'd0 || vld0 !== 1'b0 || res1 !== 16'd0 || vld1 !== 1'b0) begin
      n_fail++; $display("FAIL reset_async: res=%0h/%0h vld=%b/%b, expected 0", res0, res1, vld0, vld1);
    end
    drive(5, 5, 5, 1'b0, 1'b1, 1'b1);
    reset_l = 1'b1;
  endtask

  task automatic test_predict();
    drive(10, 20, 100, 1'b0, 1'b1, 1'b1);
    n_tests++;
    if (res0 !== 16'd85 || vld0 !== 1'b1) begin
      n_fail++; $display("FAIL fwd_hp: res=%0d vld=%b, expected 85/1", res0, vld0);
    end
    drive(10, 20, 85, 1'b0, 1'b0, 1'b1);
    n_tests++;
    if (res0 !== 16'd100) begin
      n_fail++; $display("FAIL inv_hp: res=%0d, expected 100", res0);
    end
    drive(-3, 0, 0, 1'b0, 1'b1, 1'b1);
    n_tests++;
    if (res0 !== 16'd2) begin
      n_fail++; $display("FAIL fwd_hp_neg: res=%0d, expected 2", res0);
    end
  endtask

  task automatic test_update();
    drive(4, 6, 50, 1'b1, 1'b1, 1'b1);
    n_tests++;
    if (res0 !== 16'd53) begin
      n_fail++; $display("FAIL fwd_lp: res=%0d, expected 53", res0);
    end
    drive(4, 6, 53, 1'b1, 1'b0, 1'b1);
    n_tests++;
    if (res0 !== 16'd50) begin
      n_fail++; $display("FAIL inv_lp: res=%0d, expected 50", res0);
    end
    // sum=-7: u=floor(-5/4)=-2, so forward low-pass of 0 gives -2
    drive(-3, -4, 0, 1'b1, 1'b1, 1'b1);
    n_tests++;
    if (res0 !== 16'hFFFE) begin
      n_fail++; $display("FAIL fwd_lp_neg: res=%0h, expected fffe", res0);
    end
  endtask

  task automatic test_overflow();
    drive(-2, -2, 32767, 1'b0, 1'b1, 1'b1);
    n_tests++;
    if (res0 !== 16'h8001) begin
      n_fail++; $display("FAIL ovf_wrap: res=%0h, expected 8001", res0);
    end
    n_tests++;
    if (res1 !== 16'h7FFF) begin
      n_fail++; $display("FAIL ovf_sat_hi: res=%0h, expected 7fff", res1);
    end
    // 0x8000 - 1 underflows: wraps to 0x7FFF, clamps to 0x8000
    drive(1, 1, -32768, 1'b0, 1'b1, 1'b1);
    n_tests++;
    if (res0 !== 16'h7FFF || res1 !== 16'h8000) begin
      n_fail++; $display("FAIL ovf_sat_lo: res=%0h/%0h, expected 7fff/8000", res0, res1);
    end
  endtask

  task automatic test_hold();
    drive(10, 20, 100, 1'b0, 1'b1, 1'b1);
    n_tests++;
    if (res0 !== 16'd85 || vld0 !== 1'b1) begin
      n_fail++; $display("FAIL hold_load: res=%0d vld=%b, expected 85/1", res0, vld0);
    end
    for (int i = 0; i < 3; i++) begin
      drive(i * 7 - 100, 300 + i, 1000 * i, i[0], ~i[0], 1'b0);
      n_tests++;
      if (res0 !== 16'd85 || vld0 !== 1'b0 || res1 !== 16'd85 || vld1 !== 1'b0) begin
        n_fail++; $display("FAIL hold_%0d: res=%0d vld=%b, expected 85/0", i, res0, vld0);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] e0, e1;
    int y, l, r, s;
    bit lp, fi, e;
    e0 = res0; e1 = res1;
    for (int i = 0; i < 10000; i++) begin
      l = $signed(16'($urandom)); r = $signed(16'($urandom)); s = $signed(16'($urandom));
      lp = 1'($urandom); fi = 1'($urandom); e = 1'($urandom);
      drive(l, r, s, lp, fi, e);
      if (e) begin
        y  = ref_y(l, r, s, lp, fi);
        e0 = wrap16(y);
        e1 = sat16(y);
      end
      n_tests++;
      if (res0 !== e0 || vld0 !== e || res1 !== e1 || vld1 !== e) begin
        n_fail++;
        $display("FAIL stream_%0d: res=%0h/%0h vld=%b/%b, expected %0h/%0h vld %b",
                 i, res0, res1, vld0, vld1, e0, e1, e);
      end
    end
  endtask

  task automatic test_roundtrip();
    int l, r, s;
    bit lp;
    logic [15:0] f;
    for (int i = 0; i < 200; i++) begin
      l = int'($urandom_range(16000)) - 8000;
      r = int'($urandom_range(16000)) - 8000;
      s = int'($urandom_range(16000)) - 8000;
      lp = 1'($urandom);
      drive(l, r, s, lp, 1'b1, 1'b1);
      f = res0;
      drive(l, r, $signed(f), lp, 1'b0, 1'b1);
      n_tests++;
      if (res0 !== wrap16(s)) begin
        n_fail++; $display("FAIL roundtrip_%0d: res=%0h, expected %0h", i, res0, wrap16(s));
      end
    end
  endtask

  initial begin
    reset_l = 1'b0; ex = 1'b0; l_s = '0; r_s = '0; s_s = '0;
    lohipass = 1'b0; fwd_inv = 1'b1;
    #1;
    test_reset();
    test_predict();
    test_update();
    test_overflow();
    test_hold();
    test_back_to_back();
    test_roundtrip();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
